mult_control: RTL

MULT_CONTROL -- requirements
Module: mult_control

---
 rtl/mult_control.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_control.sv
// -----------------------------------------------------------------------------
// mult_control
//
// Sequencer for a shift-and-add signed multiplier built from an X:A:B register
// chain. For each of the N_BITS multiplier bits it runs one ADD step (add the
// multiplicand into X:A when the current multiplier LSB is 1) and one SHIFT
// step (arithmetic right shift of X:A:B). The final ADD subtracts instead of
// adding, because the top multiplier bit carries negative weight in two's
// complement.
//
// Start/finish handshake (level based, no valid/ready pair):
//   The requester raises Run and holds it. The controller clears A/X, runs
//   the iterations with Busy high, then raises Done and holds the result.
//   Done stays high for as long as Run stays high; a held Run never starts a
//   second multiply. Dropping Run while Done is high returns to IDLE, after
//   which a new rising Run starts the next multiply.
//
// Ports:
//   Clk          in   clock, all state changes on its rising edge
//   Reset        in   synchronous, active high; forces IDLE, cnt=0 and holds
//                     every output at 0 while asserted
//   Run          in   start request (already synchronized and debounced)
//   ClearA_LoadB in   operator request: clear A/X and load B (IDLE only)
//   M            in   current multiplier LSB (B register Shift_Out)
//   Clr_XA       out  clear A and the sign-extension bit X
//   Ld_B         out  load B from the switches
//   Ld_XA        out  load X:A from the adder result
//   Shift_En     out  arithmetic right shift of X:A:B by one position
//   Fn           out  adder function, 0 = add, 1 = subtract
//   Busy         out  multiply in progress (START, ADD, SHIFT)
//   Done         out  result held (HOLD)
//   dbg_state    out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Clr_XA,
  output logic       Ld_B,
  output logic       Ld_XA,
  output logic       Shift_En,
  output logic       Fn,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] dbg_state
);

  // A one-bit multiply still needs a one-bit counter so the vector is legal.
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             last_iter;

  assign last_iter = (cnt == LAST_ITER);
  assign dbg_state = state;

  // State and iteration counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state and command outputs. Every output defaults to 0 so that a
  // state only names the commands it actually issues; Shift_En therefore
  // appears only in SHIFT and can never overlap a load or clear.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    Clr_XA     = 1'b0;
    Ld_B       = 1'b0;
    Ld_XA      = 1'b0;
    Shift_En   = 1'b0;
    Fn         = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;

    unique case (state)
      IDLE: begin
        // Run wins over an operator load request in the same cycle.
        if (Run) begin
          state_next = START;
        end else if (ClearA_LoadB) begin
          Ld_B   = 1'b1;
          Clr_XA = 1'b1;
        end
      end

      START: begin
        // Reloading cnt here is what keeps it from ever wrapping.
        Busy       = 1'b1;
        Clr_XA     = 1'b1;
        cnt_next   = '0;
        state_next = ADD;
      end

      ADD: begin
        // M is only meaningful here; it is the multiplier bit of this step.
        Busy       = 1'b1;
        Ld_XA      = M;
        Fn         = last_iter;
        state_next = SHIFT;
      end

      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (last_iter) begin
          state_next = HOLD;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          state_next = ADD;
        end
      end

      HOLD: begin
        // A still-high Run keeps the result; no re-trigger until Run drops.
        Done = 1'b1;
        if (!Run) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset silences every command in the same cycle it is asserted, so a
    // mid-multiply reset cannot leak one more load or shift.
    if (Reset) begin
      Clr_XA   = 1'b0;
      Ld_B     = 1'b0;
      Ld_XA    = 1'b0;
      Shift_En = 1'b0;
      Fn       = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
    end
  end

endmodule
